// File: rtl/load_ext_ctrl.sv
// Load-path controller: one sub-word load at a time, word-aligned memory read,
// lane select with sign/zero extension, response over a valid/ready handshake.
module load_ext_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_type,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      RESP     = 2'd2
   } state_t;

   localparam logic [2:0]  T_LB  = 3'b000;
   localparam logic [2:0]  T_LH  = 3'b001;
   localparam logic [2:0]  T_LW  = 3'b010;
   localparam logic [2:0]  T_LBU = 3'b100;
   localparam logic [2:0]  T_LHU = 3'b101;
   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC);

   localparam logic [1:0] E_OK      = 2'b00;
   localparam logic [1:0] E_MISALGN = 2'b01;
   localparam logic [1:0] E_ILLEGAL = 2'b10;
   localparam logic [1:0] E_TIMEOUT = 2'b11;

   state_t      state;
   logic [2:0]  type_q;
   logic [1:0]  lane_q;
   logic [15:0] cnt;
   logic        pend;

   function automatic logic is_illegal(input logic [2:0] t);
      case (t)
         T_LB, T_LH, T_LW, T_LBU, T_LHU: is_illegal = 1'b0;
         default:                        is_illegal = 1'b1;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] a);
      case (t)
         T_LH, T_LHU: is_misaligned = a[0];
         T_LW:        is_misaligned = (a != 2'b00);
         default:     is_misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] t, input logic [1:0] a,
                                          input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (t)
         T_LB:    extend = {{24{b[7]}}, b};
         T_LBU:   extend = {24'h000000, b};
         T_LH:    extend = {{16{h[15]}}, h};
         T_LHU:   extend = {16'h0000, h};
         default: extend = w;
      endcase
   endfunction

   assign req_ready = (state == IDLE) && !rst;

   // An ok response spends one cycle in RESP with pend set before rsp_valid
   // rises, giving the 3-cycle minimum acceptance-to-response latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         type_q    <= '0;
         lane_q    <= '0;
         cnt       <= '0;
         pend      <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= E_OK;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  type_q <= req_type;
                  lane_q <= req_addr[1:0];
                  if (is_illegal(req_type)) begin
                     rsp_err   <= E_ILLEGAL;
                     rsp_data  <= '0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else if (is_misaligned(req_type, req_addr[1:0])) begin
                     rsp_err   <= E_MISALGN;
                     rsp_data  <= '0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     mem_rd   <= 1'b1;
                     mem_addr <= {req_addr[31:2], 2'b00};
                     cnt      <= '0;
                     state    <= WAIT_MEM;
                  end
               end
            end
            WAIT_MEM: begin
               if (mem_rd && mem_ack) begin
                  mem_rd   <= 1'b0;
                  rsp_data <= extend(type_q, lane_q, mem_rdata);
                  rsp_err  <= E_OK;
                  pend     <= 1'b1;
                  state    <= RESP;
               end else if (cnt + 16'd1 == LIMIT) begin
                  mem_rd    <= 1'b0;
                  rsp_err   <= E_TIMEOUT;
                  rsp_data  <= '0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP: begin
               if (pend) begin
                  pend      <= 1'b0;
                  rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_rd_only_waiting: assert property (@(posedge clk) disable iff (rst)
      mem_rd |-> (state == WAIT_MEM));
   a_valid_only_resp: assert property (@(posedge clk) disable iff (rst)
      rsp_valid |-> (state == RESP));

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Directed bench for load_ext_ctrl with TIMEOUT_CYC=4; inputs change and
// outputs are checked on the falling clock edge.
module tb_load_ext_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_type;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   load_ext_ctrl #(.TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_type(req_type),
      .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   localparam logic [31:0] WORD = 32'h80FF1234;

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b1; req_addr = 32'h1000; req_type = 3'b010;
      mem_ack = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests++;
         if (req_ready !== 1'b0 || mem_rd !== 1'b0 || rsp_valid !== 1'b0 ||
             rsp_data !== 32'h0 || rsp_err !== 2'b00 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_state cyc%0d: ready=%b rd=%b valid=%b data=%h err=%b addr=%h, want all 0",
                     i, req_ready, mem_rd, rsp_valid, rsp_data, rsp_err, mem_addr);
         end
      end
      rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || mem_rd !== 1'b0 || rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: ready=%b rd=%b valid=%b, want 1 0 0", req_ready, mem_rd, rsp_valid);
      end
   endtask

   task automatic test_lanes();
      logic [2:0]  t [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100};
      logic [31:0] a [7] = '{32'h1003, 32'h1001, 32'h1002, 32'h1000, 32'h1000, 32'h1000, 32'h1003};
      logic [31:0] e [7] = '{32'hFFFFFF80, 32'h00000012, 32'hFFFF80FF, 32'h00001234,
                             32'h80FF1234, 32'h00000034, 32'h00000080};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         tests++;
         if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL lane%0d_ready: got %b want 1", i, req_ready);
         end
         req_valid = 1'b1; req_addr = a[i]; req_type = t[i];
         @(negedge clk);
         req_valid = 1'b0; req_addr = 32'hDEADBEEF; req_type = 3'b111;
         tests++;
         if (mem_rd !== 1'b1 || mem_addr !== 32'h1000 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL lane%0d_issue: rd=%b addr=%h valid=%b, want 1 00001000 0",
                     i, mem_rd, mem_addr, rsp_valid);
         end
         mem_ack = 1'b1; mem_rdata = WORD;
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = '0;
         tests++;
         if (mem_rd !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL lane%0d_cycle2: rd=%b valid=%b, want 0 0", i, mem_rd, rsp_valid);
         end
         @(negedge clk);
         tests++;
         if (rsp_valid !== 1'b1 || rsp_data !== e[i] || rsp_err !== 2'b00) begin
            fails++;
            $display("FAIL lane%0d_data: valid=%b data=%h err=%b, want 1 %h 00",
                     i, rsp_valid, rsp_data, rsp_err, e[i]);
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         tests++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL lane%0d_handshake: valid=%b ready=%b, want 0 1", i, rsp_valid, req_ready);
         end
      end
   endtask

   task automatic test_errors();
      logic [2:0]  t [4] = '{3'b001, 3'b011, 3'b111, 3'b010};
      logic [31:0] a [4] = '{32'h1001, 32'h1001, 32'h1003, 32'h1002};
      logic [1:0]  e [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_valid = 1'b1; req_addr = a[i]; req_type = t[i];
         @(negedge clk);
         req_valid = 1'b0;
         tests++;
         if (rsp_valid !== 1'b1 || rsp_err !== e[i] || rsp_data !== 32'h0 || mem_rd !== 1'b0) begin
            fails++;
            $display("FAIL err%0d: valid=%b err=%b data=%h rd=%b, want 1 %b 00000000 0",
                     i, rsp_valid, rsp_err, rsp_data, mem_rd, e[i]);
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         tests++;
         if (rsp_valid !== 1'b0 || mem_rd !== 1'b0) begin
            fails++;
            $display("FAIL err%0d_done: valid=%b rd=%b, want 0 0", i, rsp_valid, mem_rd);
         end
      end
   endtask

   task automatic test_timeout(input logic ack_last);
      int rd_cycles = 0;
      int waited    = 0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h2000; req_type = 3'b010;
      @(negedge clk);
      req_valid = 1'b0;
      while (mem_rd === 1'b1 && rd_cycles < 10) begin
         rd_cycles++;
         if (ack_last && rd_cycles == 4) begin
            mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
         end
         @(negedge clk);
         mem_ack = 1'b0;
      end
      tests++;
      if (rd_cycles != 4) begin
         fails++;
         $display("FAIL timeout_rd_len ack=%b: got %0d cycles want 4", ack_last, rd_cycles);
      end
      while (rsp_valid !== 1'b1 && waited < 5) begin
         waited++;
         @(negedge clk);
      end
      tests++;
      if (ack_last) begin
         if (rsp_valid !== 1'b1 || rsp_err !== 2'b00 || rsp_data !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL timeout_ack_wins: valid=%b err=%b data=%h, want 1 00 0badf00d",
                     rsp_valid, rsp_err, rsp_data);
         end
      end else begin
         if (rsp_valid !== 1'b1 || rsp_err !== 2'b11 || rsp_data !== 32'h0) begin
            fails++;
            $display("FAIL timeout_err: valid=%b err=%b data=%h, want 1 11 00000000",
                     rsp_valid, rsp_err, rsp_data);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h1000; req_type = 3'b101;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = WORD;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = '0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'h00001234 || rsp_err !== 2'b00 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL backpressure%0d: valid=%b data=%h err=%b ready=%b, want 1 00001234 00 0",
                     i, rsp_valid, rsp_data, rsp_err, req_ready);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 1'b0;
      tests++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_rd !== 1'b0) begin
         fails++;
         $display("FAIL backpressure_release: valid=%b ready=%b rd=%b, want 0 1 0", rsp_valid, req_ready, mem_rd);
      end
   endtask

   task automatic test_reset_midload();
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h3004; req_type = 3'b010;
      @(negedge clk);
      req_valid = 1'b0;
      tests++;
      if (mem_rd !== 1'b1 || mem_addr !== 32'h3004) begin
         fails++;
         $display("FAIL midload_issue: rd=%b addr=%h, want 1 00003004", mem_rd, mem_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (mem_rd !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_addr !== 32'h0) begin
         fails++;
         $display("FAIL midload_reset: rd=%b ready=%b valid=%b addr=%h, want 0 0 0 0",
                  mem_rd, req_ready, rsp_valid, mem_addr);
      end
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = WORD;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (rsp_valid !== 1'b0 || mem_rd !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL midload_no_rsp%0d: valid=%b rd=%b ready=%b, want 0 0 1",
                     i, rsp_valid, mem_rd, req_ready);
         end
      end
      mem_ack = 1'b0; rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lanes();
      test_errors();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_backpressure();
      test_reset_midload();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
